// File: rtl/uart_frame_packer.sv
// Frame packer: GO -> SYNC0, SYNC1, WORDS x 4 bytes LSB first (+ XOR trailer when CHECKSUM_EN is defined).
// Latency: TX_START two cycles after GO; 4 cycles of read overhead per word; FRAME_DONE 2 cycles after last BUSY fall.
// Backpressure: waits indefinitely on TX_BUSY (START only while idle, one pulse per byte); ABORT drops to idle.
module uart_frame_packer #(
  parameter int         WORDS  = 768,
  parameter int         ADDR_W = 12,
  parameter logic [7:0] SYNC0  = 8'hA5,
  parameter logic [7:0] SYNC1  = 8'h5A
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              go,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [31:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              frame_busy,
  output logic              frame_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_SEND, S_ACK, S_DRAIN, S_FETCH, S_RDW1, S_RDW2, S_CSUM, S_FIN
  } state_t;

  // Identifies the byte currently held in tx_data.
  localparam logic [2:0] B_SYNC0 = 3'd0, B_SYNC1 = 3'd1, B_W0 = 3'd2,
                         B_W1 = 3'd3, B_W2 = 3'd4, B_W3 = 3'd5, B_CSUM = 3'd6;
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(WORDS);

  state_t            state, state_n;
  logic [2:0]        byte_idx, byte_idx_n;
  logic [ADDR_W:0]   word_cnt, word_cnt_n;
  logic [31:0]       word_buf, word_buf_n;
  logic [7:0]        tx_data_n, next_byte;
  logic [ADDR_W-1:0] rd_addr_n;
  logic              tx_start_n, rd_en_n, frame_busy_n, frame_done_n;
`ifdef CHECKSUM_EN
  logic [7:0]        csum, csum_n;
`endif

  always_comb begin
    case (byte_idx)
      B_W0:    next_byte = word_buf[15:8];
      B_W1:    next_byte = word_buf[23:16];
      default: next_byte = word_buf[31:24];
    endcase
  end

  always_comb begin
    state_n      = state;
    byte_idx_n   = byte_idx;
    word_cnt_n   = word_cnt;
    word_buf_n   = word_buf;
    tx_data_n    = tx_data;
    rd_addr_n    = rd_addr;
    tx_start_n   = 1'b0;
    rd_en_n      = 1'b0;
    frame_busy_n = frame_busy;
    frame_done_n = 1'b0;
`ifdef CHECKSUM_EN
    csum_n       = csum;
`endif
    if (state != S_IDLE && abort) begin
      state_n      = S_IDLE;
      frame_busy_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (go && !abort) begin
          state_n      = S_SEND;
          word_cnt_n   = '0;
          tx_data_n    = SYNC0;
          byte_idx_n   = B_SYNC0;
          frame_busy_n = 1'b1;
`ifdef CHECKSUM_EN
          csum_n       = 8'h00;
`endif
        end
        S_SEND: if (!tx_busy) begin
          tx_start_n = 1'b1;
          state_n    = S_ACK;
        end
        S_ACK: if (tx_busy) state_n = S_DRAIN;
        S_DRAIN: if (!tx_busy) begin
          case (byte_idx)
            B_SYNC0: begin
              tx_data_n  = SYNC1;
              byte_idx_n = B_SYNC1;
              state_n    = S_SEND;
            end
            B_W0, B_W1, B_W2: begin
              tx_data_n  = next_byte;
              byte_idx_n = byte_idx + 3'd1;
              state_n    = S_SEND;
`ifdef CHECKSUM_EN
              csum_n     = csum ^ next_byte;
`endif
            end
            B_SYNC1, B_W3: begin
              if (word_cnt != LAST_WORD) begin
                // rd_en/rd_addr are registered, so they are set on entry to FETCH.
                state_n   = S_FETCH;
                rd_en_n   = 1'b1;
                rd_addr_n = word_cnt[ADDR_W-1:0];
              end else begin
`ifdef CHECKSUM_EN
                state_n = S_CSUM;
`else
                state_n = S_FIN;
`endif
              end
            end
            default: state_n = S_FIN;
          endcase
        end
        S_FETCH: state_n = S_RDW1;
        S_RDW1:  state_n = S_RDW2;
        S_RDW2: begin
          word_buf_n = rd_data;
          tx_data_n  = rd_data[7:0];
          byte_idx_n = B_W0;
          word_cnt_n = word_cnt + 1'b1;
          state_n    = S_SEND;
`ifdef CHECKSUM_EN
          csum_n     = csum ^ rd_data[7:0];
`endif
        end
`ifdef CHECKSUM_EN
        S_CSUM: begin
          tx_data_n  = csum;
          byte_idx_n = B_CSUM;
          state_n    = S_SEND;
        end
`endif
        S_FIN: begin
          frame_done_n = 1'b1;
          frame_busy_n = 1'b0;
          state_n      = S_IDLE;
        end
        default: begin
          state_n      = S_IDLE;
          frame_busy_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_idx   <= B_SYNC0;
      word_cnt   <= '0;
      word_buf   <= '0;
      tx_data    <= 8'h00;
      rd_addr    <= '0;
      tx_start   <= 1'b0;
      rd_en      <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
`ifdef CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      state      <= state_n;
      byte_idx   <= byte_idx_n;
      word_cnt   <= word_cnt_n;
      word_buf   <= word_buf_n;
      tx_data    <= tx_data_n;
      rd_addr    <= rd_addr_n;
      tx_start   <= tx_start_n;
      rd_en      <= rd_en_n;
      frame_busy <= frame_busy_n;
      frame_done <= frame_done_n;
`ifdef CHECKSUM_EN
      csum       <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer with a 2-word RAM and a behavioural UART transmitter.
module tb_uart_frame_packer;
  localparam int BUSY_CYC = 10;
`ifdef CHECKSUM_EN
  localparam int N_EXP = 11;
`else
  localparam int N_EXP = 10;
`endif

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        tx_busy = 1'b0;
  logic [31:0] rd_data = 32'h0;
  logic [11:0] rd_addr;
  logic        rd_en, tx_start, frame_busy, frame_done;
  logic [7:0]  tx_data;

  int vectors = 0;
  int miscompares = 0;

  // payload XOR: 44^33^22^11 = 44, DD^CC^BB^AA = 00
  logic [7:0] exp_bytes [0:10] = '{8'hA5, 8'h5A, 8'h44, 8'h33, 8'h22, 8'h11,
                                   8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
  logic [31:0] mem [0:1] = '{32'h11223344, 32'hAABBCCDD};

  always #5 clock = ~clock;

  uart_frame_packer #(.WORDS(2), .ADDR_W(12), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
    .clock(clock), .rst_n(rst_n), .go(go), .abort(abort),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .frame_busy(frame_busy), .frame_done(frame_done)
  );

  // Registered-address, registered-output RAM; data is valid for one cycle only.
  logic        en_q = 1'b0;
  logic [11:0] addr_q = 12'h0;
  always @(posedge clock) begin
    en_q <= rd_en;
    if (rd_en) addr_q <= rd_addr;
    rd_data <= en_q ? mem[addr_q[0]] : 32'hDEADBEEF;
  end

  // Transmitter model and protocol monitor, evaluated mid-cycle.
  logic [7:0]  byte_q [$];
  logic [11:0] rd_log [$];
  int done_cnt = 0, dup_cnt = 0, illegal_cnt = 0, unstable_cnt = 0;
  int pend = 0, busy_left = 0, rise_dly = 0;
  logic prev_start = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  always @(negedge clock) begin
    if (rd_en) rd_log.push_back(rd_addr);
    if (frame_done) done_cnt++;
    if (tx_start && prev_start) dup_cnt++;
    prev_start = tx_start;
    if ((tx_busy || pend > 0) && tx_data !== cur_byte) unstable_cnt++;
    if (tx_start) begin
      if (tx_busy || pend > 0) illegal_cnt++;
      else begin
        byte_q.push_back(tx_data);
        cur_byte = tx_data;
        if (rise_dly == 0) begin tx_busy = 1'b1; busy_left = BUSY_CYC; end
        else pend = rise_dly;
      end
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin tx_busy = 1'b1; busy_left = BUSY_CYC; end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic run_frame(output bit timed_out);
    int d;
    d = done_cnt;
    go = 1'b1;
    step();
    go = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (done_cnt > d) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic wait_tx_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!tx_busy && pend == 0) begin timed_out = 1'b0; break; end
      step();
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    vectors++; if (rd_addr !== 12'h0) begin miscompares++; $display("FAIL reset_rd_addr: got %h want 000", rd_addr); end
    vectors++; if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL reset_frame_busy: got %b want 0", frame_busy); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_frame();
    int s, r, d, dp, il, un;
    bit to;
    s = byte_q.size(); r = rd_log.size(); d = done_cnt;
    dp = dup_cnt; il = illegal_cnt; un = unstable_cnt;
    go = 1'b1;
    step();
    go = 1'b0;
    vectors++; if (frame_busy !== 1'b1) begin miscompares++; $display("FAIL go_frame_busy: got %b want 1", frame_busy); end
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL go_early_start: got %b want 0", tx_start); end
    step();
    vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL first_tx_start: got %b want 1", tx_start); end
    vectors++; if (tx_data !== 8'hA5) begin miscompares++; $display("FAIL first_tx_data: got %h want a5", tx_data); end
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (done_cnt > d) begin to = 1'b0; break; end
    end
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL frame_timeout: got %b want 0", to); end
    vectors++; if (byte_q.size() - s !== N_EXP) begin miscompares++; $display("FAIL frame_len: got %0d want %0d", byte_q.size() - s, N_EXP); end
    for (int i = 0; i < N_EXP; i++) begin
      vectors++; if (byte_q[s+i] !== exp_bytes[i]) begin miscompares++; $display("FAIL frame_byte%0d: got %h want %h", i, byte_q[s+i], exp_bytes[i]); end
    end
    vectors++; if (rd_log.size() - r !== 2) begin miscompares++; $display("FAIL rd_en_count: got %0d want 2", rd_log.size() - r); end
    vectors++; if (rd_log[r] !== 12'd0) begin miscompares++; $display("FAIL rd_addr0: got %h want 000", rd_log[r]); end
    vectors++; if (rd_log[r+1] !== 12'd1) begin miscompares++; $display("FAIL rd_addr1: got %h want 001", rd_log[r+1]); end
    vectors++; if (done_cnt - d !== 1) begin miscompares++; $display("FAIL frame_done_count: got %0d want 1", done_cnt - d); end
    vectors++; if (dup_cnt - dp !== 0) begin miscompares++; $display("FAIL start_width: got %0d want 0", dup_cnt - dp); end
    vectors++; if (illegal_cnt - il !== 0) begin miscompares++; $display("FAIL start_while_busy: got %0d want 0", illegal_cnt - il); end
    vectors++; if (unstable_cnt - un !== 0) begin miscompares++; $display("FAIL tx_data_stable: got %0d want 0", unstable_cnt - un); end
  endtask

  task automatic test_abort();
    int s, d, s2;
    bit to;
    s = byte_q.size(); d = done_cnt;
    go = 1'b1;
    step();
    go = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (byte_q.size() >= s + 5) begin to = 1'b0; break; end
      step();
    end
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL abort_reach_timeout: got %b want 0", to); end
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++; if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got %b want 0", frame_busy); end
    for (int i = 0; i < 40; i++) step();
    vectors++; if (byte_q.size() - s !== 5) begin miscompares++; $display("FAIL abort_bytes: got %0d want 5", byte_q.size() - s); end
    vectors++; if (done_cnt - d !== 0) begin miscompares++; $display("FAIL abort_done: got %0d want 0", done_cnt - d); end
    wait_tx_idle(to);
    s2 = byte_q.size(); d = done_cnt;
    run_frame(to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL restart_timeout: got %b want 0", to); end
    vectors++; if (byte_q.size() - s2 !== N_EXP) begin miscompares++; $display("FAIL restart_len: got %0d want %0d", byte_q.size() - s2, N_EXP); end
    for (int i = 0; i < N_EXP; i++) begin
      vectors++; if (byte_q[s2+i] !== exp_bytes[i]) begin miscompares++; $display("FAIL restart_byte%0d: got %h want %h", i, byte_q[s2+i], exp_bytes[i]); end
    end
    vectors++; if (done_cnt - d !== 1) begin miscompares++; $display("FAIL restart_done: got %0d want 1", done_cnt - d); end
  endtask

  task automatic test_go_ignored();
    int s, d;
    bit to;
    s = byte_q.size(); d = done_cnt;
    go = 1'b1;
    step();
    go = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (byte_q.size() == s + 3 || byte_q.size() == s + 7) begin go = 1'b1; step(); go = 1'b0; end
      if (byte_q.size() >= s + N_EXP) begin to = 1'b0; break; end
      step();
    end
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL midgo_timeout: got %b want 0", to); end
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!tx_busy) begin to = 1'b0; break; end
      step();
    end
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL last_busy_timeout: got %b want 0", to); end
    // DUT sampled BUSY low on the last edge, so this cycle is FIN.
    go = 1'b1;
    step();
    go = 1'b0;
    vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL done_timing: got %b want 1", frame_done); end
    vectors++; if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL busy_with_done: got %b want 0", frame_busy); end
    step();
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %b want 0", frame_done); end
    vectors++; if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL fin_go_ignored: got %b want 0", frame_busy); end
    for (int i = 0; i < 20; i++) step();
    vectors++; if (byte_q.size() - s !== N_EXP) begin miscompares++; $display("FAIL midgo_len: got %0d want %0d", byte_q.size() - s, N_EXP); end
    vectors++; if (done_cnt - d !== 1) begin miscompares++; $display("FAIL midgo_done: got %0d want 1", done_cnt - d); end
  endtask

  task automatic test_rise_delay();
    int s, dp, il, un;
    bit to;
    s = byte_q.size(); dp = dup_cnt; il = illegal_cnt; un = unstable_cnt;
    rise_dly = 3;
    run_frame(to);
    rise_dly = 0;
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL delay_timeout: got %b want 0", to); end
    vectors++; if (byte_q.size() - s !== N_EXP) begin miscompares++; $display("FAIL delay_len: got %0d want %0d", byte_q.size() - s, N_EXP); end
    vectors++; if (byte_q[s+N_EXP-1] !== exp_bytes[N_EXP-1]) begin miscompares++; $display("FAIL delay_last: got %h want %h", byte_q[s+N_EXP-1], exp_bytes[N_EXP-1]); end
    vectors++; if (dup_cnt - dp !== 0) begin miscompares++; $display("FAIL delay_dup_start: got %0d want 0", dup_cnt - dp); end
    vectors++; if (illegal_cnt - il !== 0) begin miscompares++; $display("FAIL delay_restart: got %0d want 0", illegal_cnt - il); end
    vectors++; if (unstable_cnt - un !== 0) begin miscompares++; $display("FAIL delay_tx_data_stable: got %0d want 0", unstable_cnt - un); end
  endtask

  task automatic test_reset_mid();
    int s, s2;
    bit to;
    s = byte_q.size();
    go = 1'b1;
    step();
    go = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (byte_q.size() >= s + 7) begin to = 1'b0; break; end
      step();
    end
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL rstmid_reach_timeout: got %b want 0", to); end
    vectors++; if (rd_addr !== 12'd1) begin miscompares++; $display("FAIL rstmid_pre_addr: got %h want 001", rd_addr); end
    rst_n = 1'b0;
    #1;
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
    vectors++; if (rd_addr !== 12'h0) begin miscompares++; $display("FAIL rstmid_rd_addr: got %h want 000", rd_addr); end
    vectors++; if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_frame_busy: got %b want 0", frame_busy); end
    vectors++; if (tx_start !== 1'b0 || rd_en !== 1'b0 || frame_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_pulses: got %b%b%b want 000", tx_start, rd_en, frame_done); end
    step();
    step();
    rst_n = 1'b1;
    step();
    wait_tx_idle(to);
    s2 = byte_q.size();
    run_frame(to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL rstmid_frame_timeout: got %b want 0", to); end
    vectors++; if (byte_q.size() - s2 !== N_EXP) begin miscompares++; $display("FAIL rstmid_len: got %0d want %0d", byte_q.size() - s2, N_EXP); end
    for (int i = 0; i < N_EXP; i++) begin
      vectors++; if (byte_q[s2+i] !== exp_bytes[i]) begin miscompares++; $display("FAIL rstmid_byte%0d: got %h want %h", i, byte_q[s2+i], exp_bytes[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_abort();
    test_go_ignored();
    test_rise_delay();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
